// File: rtl/fetch_stage_pkg.sv
// Purpose : shared pipeline constants, instruction helpers and fetch FSM encoding.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package fetch_stage_pkg;

   localparam int PC_W_DEF    = 32;
   localparam int IMEM_AW_DEF = 10;
   localparam int CNT_W_DEF   = 32;

   // All-zero word doubles as the pipeline bubble.
   localparam logic [31:0] NOP         = 32'h0000_0000;
   localparam logic [5:0]  HALT_OP_DEF = 6'b111111;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   function automatic logic [5:0] opcode_of(input logic [31:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Purpose : bundle of fetch-stage control, instruction-memory and IF/ID signals.
// Latency : n/a (wiring only).
// Backpressure: i_stall/i_enable freeze the stage; no ready/valid return path.
// Ports   : master = fetch stage (drives o_*), slave = surrounding pipeline/debug (drives i_*).
interface fetch_stage_if
   import fetch_stage_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int IMEM_AW = IMEM_AW_DEF,
   parameter int CNT_W   = CNT_W_DEF
);
   logic               i_enable;
   logic               i_stall;
   logic               i_taken;
   logic [PC_W-1:0]    i_jump_address;
   logic [IMEM_AW-1:0] o_imem_addr;
   logic [31:0]        i_imem_data;
   logic [PC_W-1:0]    o_pc;
   logic [31:0]        o_instr;
   logic               o_valid;
   logic               o_flush;
   logic               o_halted;
   logic [PC_W-1:0]    o_pc_cur;
   logic [CNT_W-1:0]   o_cycles;

   modport master (
      input  i_enable, i_stall, i_taken, i_jump_address, i_imem_data,
      output o_imem_addr, o_pc, o_instr, o_valid, o_flush, o_halted, o_pc_cur, o_cycles
   );

   modport slave (
      output i_enable, i_stall, i_taken, i_jump_address, i_imem_data,
      input  o_imem_addr, o_pc, o_instr, o_valid, o_flush, o_halted, o_pc_cur, o_cycles
   );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Purpose : IF/ID pipeline latch (pc, instr, valid) with hold, bubble and load controls.
// Latency : 1 cycle from pc_in/instr_in to outputs.
// Backpressure: hold freezes contents; priority hold > bubble > load, otherwise contents stay.
// Ports   : clk, rst (sync, active-high); hold/bubble/load controls; pc_in/instr_in data;
//           pc/instr/valid registered outputs.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hold,
   input  logic            bubble,
   input  logic            load,
   input  logic [PC_W-1:0] pc_in,
   input  logic [31:0]     instr_in,
   output logic [PC_W-1:0] pc,
   output logic [31:0]     instr,
   output logic            valid
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= '0;
         instr <= NOP;
         valid <= 1'b0;
      end else if (hold) begin
         pc    <= pc;
         instr <= instr;
         valid <= valid;
      end else if (bubble) begin
         pc    <= '0;
         instr <= NOP;
         valid <= 1'b0;
      end else if (load) begin
         pc    <= pc_in;
         instr <= instr_in;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Purpose : instruction fetch (PC, HALT FSM, debug cycle counter) feeding the IF/ID register.
// Latency : 1 cycle PC -> IF/ID; o_imem_addr is combinational from the PC.
// Backpressure: i_enable=0 freezes everything; i_stall holds PC and IF/ID (wins over i_taken).
// Ports   : clk, rst (sync, active-high); bus (fetch_stage_if.master) carrying enable/stall,
//           branch decision, instruction-memory address/data, IF/ID outputs and debug status.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int          PC_W    = PC_W_DEF,
   parameter int          IMEM_AW = IMEM_AW_DEF,
   parameter logic [5:0]  HALT_OP = HALT_OP_DEF,
   parameter int          CNT_W   = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  pc_plus1;
   fetch_state_t     state;
   logic             flush;
   logic [CNT_W-1:0] cycles;

   logic ifid_hold;
   logic ifid_bubble;
   logic ifid_load;
   logic fetch_is_halt;

   assign pc_plus1         = pc + PC_W'(1);
   assign bus.o_imem_addr  = pc[IMEM_AW-1:0];
   assign fetch_is_halt    = (opcode_of(bus.i_imem_data) == HALT_OP);

   // IF/ID control: a stall or a disabled cycle freezes the latch; once halted, or on a
   // taken branch, the word on the memory bus is discarded and a bubble goes downstream.
   assign ifid_hold   = !bus.i_enable || bus.i_stall;
   assign ifid_bubble = (state == HALTED) || bus.i_taken;
   assign ifid_load   = bus.i_enable && (state == RUN) && !bus.i_stall && !bus.i_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= '0;
         state  <= RUN;
         flush  <= 1'b0;
         cycles <= '0;
      end else if (bus.i_enable) begin
         if (state == HALTED) begin
            flush <= 1'b0;
         end else begin
            // Every enabled RUN cycle counts, stalls and flushes included.
            cycles <= cycles + CNT_W'(1);
            if (bus.i_stall) begin
               flush <= 1'b0;
            end else if (bus.i_taken) begin
               pc    <= bus.i_jump_address;
               flush <= 1'b1;
            end else begin
               pc    <= pc_plus1;
               flush <= 1'b0;
               if (fetch_is_halt) begin
                  state <= HALTED;
               end
            end
         end
      end
   end

   if_id_reg #(.PC_W(PC_W)) u_if_id (
      .clk      (clk),
      .rst      (rst),
      .hold     (ifid_hold),
      .bubble   (ifid_bubble),
      .load     (ifid_load),
      .pc_in    (pc_plus1),
      .instr_in (bus.i_imem_data),
      .pc       (bus.o_pc),
      .instr    (bus.o_instr),
      .valid    (bus.o_valid)
   );

   assign bus.o_flush  = flush;
   assign bus.o_halted = (state == HALTED);
   assign bus.o_pc_cur = pc;
   assign bus.o_cycles = cycles;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : scoreboard bench for fetch_stage; directed scenarios then randomized traffic.
// Latency : expected outputs are compared 1 ns after the edge that produced them.
// Backpressure: stall/enable/taken/reset driven directly from the stimulus thread.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_stage_if bus ();

   fetch_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] imem [0:1023];
   assign bus.i_imem_data = imem[bus.o_imem_addr];

   typedef struct {
      logic [31:0] pc_cur;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
      logic        flush;
      logic        halted;
      logic [31:0] cyc;
      logic [9:0]  addr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   // Reference model state: what the stage should look like after each edge.
   logic [31:0] m_pc, m_opc, m_instr, m_cyc;
   bit          m_valid, m_flush, m_halted;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rand_word(input int halt_pct);
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(99) < halt_pct) w[31:26] = 6'h3f;
      else if (w[31:26] == 6'h3f)        w[31:26] = 6'h00;
      return w;
   endfunction

   task automatic step(input bit r, input bit en, input bit st, input bit tk,
                       input logic [31:0] tgt);
      logic [31:0] w;
      exp_t e;
      @(negedge clk);
      rst                = r;
      bus.i_enable       = en;
      bus.i_stall        = st;
      bus.i_taken        = tk;
      bus.i_jump_address = tgt;
      if (r) begin
         m_pc = 0; m_opc = 0; m_instr = 0; m_cyc = 0;
         m_valid = 0; m_flush = 0; m_halted = 0;
      end else if (en) begin
         if (m_halted) begin
            if (!st) begin m_opc = 0; m_instr = 0; m_valid = 0; end
            m_flush = 0;
         end else begin
            m_cyc = m_cyc + 1;
            if (st) begin
               m_flush = 0;
            end else if (tk) begin
               m_pc = tgt; m_opc = 0; m_instr = 0; m_valid = 0; m_flush = 1;
            end else begin
               w       = imem[m_pc % 1024];
               m_pc    = m_pc + 1;
               m_opc   = m_pc;
               m_instr = w;
               m_valid = 1;
               m_flush = 0;
               if ((w >> 26) == 63) m_halted = 1;
            end
         end
      end
      e.pc_cur = m_pc;  e.pc = m_opc;    e.instr = m_instr; e.valid = m_valid;
      e.flush = m_flush; e.halted = m_halted; e.cyc = m_cyc;
      e.addr  = 10'(m_pc % 1024);
      sb.push_back(e);
   endtask

   // Memory edits happen only after the pending edge has consumed the current word.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, 32'h0);
   endtask

   // Monitor: every edge that has a pending expectation is checked field by field.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("pc_cur",    bus.o_pc_cur,           mon_e.pc_cur);
         check("ifid_pc",   bus.o_pc,               mon_e.pc);
         check("instr",     bus.o_instr,            mon_e.instr);
         check("valid",     32'(bus.o_valid),       32'(mon_e.valid));
         check("flush",     32'(bus.o_flush),       32'(mon_e.flush));
         check("halted",    32'(bus.o_halted),      32'(mon_e.halted));
         check("cycles",    bus.o_cycles,           mon_e.cyc);
         check("imem_addr", 32'(bus.o_imem_addr),   32'(mon_e.addr));
      end
   end

   initial begin
      rst = 1'b1;
      bus.i_enable = 0; bus.i_stall = 0; bus.i_taken = 0; bus.i_jump_address = '0;
      for (int i = 0; i < 1024; i++) imem[i] = rand_word(0);
      imem[0] = 32'h2001_0005; imem[1] = 32'h2002_0007; imem[2] = 32'h0; imem[3] = 32'h0;

      // Reset, basic fetch, stall at PC=2, taken at PC=5.
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      run_n(2);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      run_n(3);
      step(0, 1, 0, 1, 32'h40);
      run_n(2);
      // Stall and taken together: stall wins; taken afterwards behaves normally.
      step(0, 1, 1, 1, 32'h80);
      step(0, 1, 0, 1, 32'h80);
      run_n(1);
      // Disabled cycles, even with stall/taken asserted, change nothing.
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h123);
      step(0, 0, 1, 0, 0);
      run_n(1);
      // PC and memory-address wrap.
      step(0, 1, 0, 1, 32'hFFFF_FFFF);
      run_n(2);
      step(0, 1, 0, 1, 32'h0000_03FF);
      run_n(2);

      // HALT fetched at word 3.
      settle();
      imem[3] = 32'hFC00_0000;
      step(1, 1, 0, 0, 0);
      run_n(4);
      run_n(2);
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 1, 32'h20);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      run_n(2);

      // Taken branch in the cycle HALT is on the bus discards it.
      step(1, 1, 0, 0, 0);
      run_n(3);
      step(0, 1, 0, 1, 32'h10);
      run_n(3);

      // Randomized traffic with sparse HALT words.
      settle();
      for (int i = 0; i < 1024; i++) imem[i] = rand_word(3);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) < 2,
              $urandom_range(9) != 0,
              $urandom_range(99) < 20,
              $urandom_range(99) < 15,
              ($urandom_range(7) == 0) ? $urandom : 32'($urandom_range(1100)));
      end

      @(posedge clk);
      #3;
      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the MIPS pipeline.
- Holds the PC and addresses the instruction memory.
- Consumes the ID-stage branch decision (taken flag and target) and the hazard-unit stall.
- Presents PC+1 and the fetched instruction to ID.
- Detects the HALT opcode and freezes fetch, with a debug step-enable and a cycle counter for the debug unit.
- PC is a word address: +1 per instruction; branch/jump targets are absolute word addresses.

Parameters:
PC_W, 32, PC and target width
IMEM_AW, 10, instruction-memory address width; PC is taken modulo 2^IMEM_AW for addressing
HALT_OP, 6'b111111, opcode (instr[31:26]) that halts fetch
CNT_W, 32, cycle counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_enable  in  1  debug step/run enable; low freezes the whole block
i_stall  in  1  hazard-unit stall; hold PC and IF/ID
i_taken  in  1  ID-stage branch/jump taken
i_jump_address  in  PC_W  absolute target when i_taken
o_imem_addr  out  IMEM_AW  = PC[IMEM_AW-1:0], combinational
i_imem_data  in  32  instruction at o_imem_addr, same-cycle (async read)
o_pc  out  PC_W  IF/ID: fetched PC+1 (link/branch base for ID)
o_instr  out  32  IF/ID: instruction, 32'h0 (NOP) when bubble
o_valid  out  1  IF/ID holds a real instruction
o_flush  out  1  registered: previous edge inserted a flush bubble
o_halted  out  1  FSM in HALTED
o_pc_cur  out  PC_W  current PC (debug)
o_cycles  out  CNT_W  cycles executed while RUN and enabled

Behaviour:
Reset (rst=1 at edge), with priority over everything:
- PC=0, o_pc=0, o_instr=0, o_valid=0, o_flush=0, state=RUN, o_cycles=0.

FSM states: RUN, HALTED.

Per-edge priority when not in reset:
1. i_enable=0: all registers hold, counter included.
2. state=HALTED: PC holds. If i_stall=1, IF/ID holds; else IF/ID loads bubble (instr=0, valid=0). o_flush=0. Counter holds. HALTED is left only by rst.
3. i_stall=1: PC and IF/ID hold; o_flush=0. Stall wins over i_taken, because the branch operands are unresolved.
4. i_taken=1: PC<=i_jump_address; IF/ID <= bubble (instr=0, valid=0, o_pc=0); o_flush<=1. The instruction fetched this cycle is discarded, even if it is HALT. There is no delay slot.
5. Normal: PC<=PC+1; o_pc<=PC+1; o_instr<=i_imem_data; o_valid<=1; o_flush<=0. If i_imem_data[31:26]==HALT_OP, state<=HALTED on the same edge. The HALT word is latched into IF/ID once and propagates downstream.

Counter and PC rules:
- o_cycles increments on every enabled edge while state=RUN, including stall and flush cycles; wraps modulo 2^CNT_W.
- PC+1 wraps modulo 2^PC_W.
- o_imem_addr wraps modulo 2^IMEM_AW; no error flag.

Reset and outputs:
- Reset mid-stall, mid-flush or while HALTED returns to the reset state next edge.
- All outputs except o_imem_addr are registered; latency from PC to IF/ID is 1 cycle.

Decomposition:
- Shared pipeline package: NOP (32'h0), HALT_OP, opcode field slice [31:26], FSM encoding (RUN=1'b0, HALTED=1'b1).
- One natural sub-module: if_id_reg. It is the IF/ID latch with hold, bubble and load controls (pc, instr, valid), reused by the pattern for later pipeline registers.
- PC, FSM and counter stay in fetch_stage.

Test Plan:
- Reset then enable with imem[0..3]=0x20010005,0x20020007,0,0 → o_pc=1,2,3 and o_instr matches on successive cycles; o_valid=1; o_cycles=3 after 3 edges.
- Stall: i_stall=1 for 2 cycles at PC=2 → PC, o_pc and o_instr unchanged; o_cycles still increments; after release, fetch resumes at 2.
- Taken: i_taken=1 with i_jump_address=0x40 at PC=5 → next cycle o_instr=0, o_valid=0, o_flush=1, o_pc_cur=0x40; following cycle o_pc=0x41 with imem[0x40].
- Stall+taken in the same cycle → stall wins: PC held, no flush; taken on a later cycle acts normally.
- HALT at imem[3]=0xFC000000 → IF/ID carries 0xFC000000 once; then o_halted=1, o_instr=0, PC frozen at 4, counter frozen. A taken branch in the cycle HALT is fetched → HALT discarded, no halt.
- i_enable=0 for 3 cycles mid-run, then rst=1 while HALTED → nothing changes while disabled; after reset all outputs are 0 and state=RUN.
